// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared types and defaults for the add-shift multiplier and the
//             front-end that shares it among several requesters.
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    localparam int N_REQ_DEFAULT   = 4;
    localparam int WIDTH_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 63;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DELIVER   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick: first set request strictly after
//             the pointer, wrapping. Returns one-hot grant and its index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_any
);
    localparam int IW = $clog2(N_REQ);

    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Offset 1..N so the last winner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_share_arbiter
//  Brief    : Round-robin front-end sharing one start/ready multiplier among
//             N_REQ clients, with operand latching and a hang watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_A,
    input  logic [N_REQ*WIDTH-1:0]   req_B,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic [N_REQ-1:0]         resp_ready,
    output logic [2*WIDTH-1:0]       resp_result,
    output logic                     resp_err,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_ABus,
    output logic [WIDTH-1:0]         mult_BBus,
    input  logic                     mult_ready,
    input  logic [2*WIDTH-1:0]       mult_resultBus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int               IW        = $clog2(N_REQ);
    localparam int               WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]   C_TIMEOUT = WDW'(TIMEOUT);
    localparam logic [IW-1:0]    C_PTR_RST = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] C_ONE     = N_REQ'(1);

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_ptr, w_ptr_nxt;
    logic [IW-1:0]      r_gid, w_gid_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [N_REQ-1:0]   r_ack, w_ack_nxt;
    logic [N_REQ-1:0]   r_valid, w_valid_nxt;
    logic [2*WIDTH-1:0] r_result, w_result_nxt;
    logic               r_err, w_err_nxt;
    logic               r_start, w_start_nxt;
    logic               r_busy, w_busy_nxt;
    logic [WDW-1:0]     r_wdog, w_wdog_nxt;

    logic [N_REQ-1:0]   w_arb_grant;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_expired;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (r_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .grant_any (w_arb_any)
    );

    assign w_onehot  = C_ONE << r_gid;
    assign w_expired = (r_wdog == C_TIMEOUT);

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gid_nxt    = r_gid;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_ack_nxt    = '0;
        w_valid_nxt  = r_valid;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_start_nxt  = r_start;
        w_wdog_nxt   = r_wdog;

        case (r_state)
            IDLE: begin
                w_start_nxt = 1'b0;
                w_valid_nxt = '0;
                w_err_nxt   = 1'b0;
                if (w_arb_any && mult_ready) begin
                    w_gid_nxt   = w_arb_idx;
                    w_ptr_nxt   = w_arb_idx;
                    w_a_nxt     = req_A[w_arb_idx*WIDTH +: WIDTH];
                    w_b_nxt     = req_B[w_arb_idx*WIDTH +: WIDTH];
                    w_ack_nxt   = w_arb_grant;
                    w_start_nxt = 1'b1;
                    w_wdog_nxt  = '0;
                    w_state_nxt = ISSUE;
                end
            end

            ISSUE, WAIT_DONE: begin
                if (w_expired) begin
                    // Abandon the job; the multiplier is left to finish on its own.
                    w_start_nxt  = 1'b0;
                    w_result_nxt = '0;
                    w_err_nxt    = 1'b1;
                    w_valid_nxt  = w_onehot;
                    w_state_nxt  = DELIVER;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                    if (r_state == ISSUE) begin
                        if (!mult_ready) begin
                            w_start_nxt = 1'b0;
                            w_state_nxt = WAIT_DONE;
                        end
                    end else if (mult_ready) begin
                        w_result_nxt = mult_resultBus;
                        w_err_nxt    = 1'b0;
                        w_valid_nxt  = w_onehot;
                        w_state_nxt  = DELIVER;
                    end
                end
            end

            DELIVER: begin
                if (resp_ready[r_gid]) begin
                    w_valid_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= C_PTR_RST;
            r_gid    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ack    <= '0;
            r_valid  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gid    <= w_gid_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_ack    <= w_ack_nxt;
            r_valid  <= w_valid_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
            r_start  <= w_start_nxt;
            r_busy   <= w_busy_nxt;
            r_wdog   <= w_wdog_nxt;
        end
    end

    assign req_ack     = r_ack;
    assign resp_valid  = r_valid;
    assign resp_result = r_result;
    assign resp_err    = r_err;
    assign mult_start  = r_start;
    assign mult_ABus   = r_a;
    assign mult_BBus   = r_b;
    assign busy        = r_busy;
    assign grant_id    = r_gid;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_share_arbiter
//  Brief    : Directed/randomised bench with a behavioural multiplier and a
//             round-robin reference for grant order and products.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int T = 63;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_A = '0;
    logic [N*W-1:0]   req_B = '0;
    logic [N-1:0]     resp_ready = '1;
    logic [N-1:0]     req_ack;
    logic [N-1:0]     resp_valid;
    logic [2*W-1:0]   resp_result;
    logic             resp_err;
    logic             mult_start;
    logic [W-1:0]     mult_ABus;
    logic [W-1:0]     mult_BBus;
    logic             mult_ready;
    logic [2*W-1:0]   mult_resultBus;
    logic             busy;
    logic [$clog2(N)-1:0] grant_id;

    int n_cmp = 0;
    int n_fail = 0;
    int rr_ptr = N - 1;
    int gq[$];
    int rq[$];

    // Behavioural multiplier: accepts start while idle, busy for m_cnt+1 cycles.
    bit             m_busy = 1'b0;
    bit             force_busy = 1'b0;
    bit             hang = 1'b0;
    int             fixed_lat = 0;
    int             m_cnt = 0;
    logic [2*W-1:0] m_prod = '0;

    assign mult_ready     = !m_busy && !force_busy;
    assign mult_resultBus = m_prod;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!m_busy) begin
            if (mult_start && !force_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 12));
                m_prod <= (2*W)'(mult_ABus) * (2*W)'(mult_BBus);
            end
        end else if (!hang) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    mult_share_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_A          (req_A),
        .req_B          (req_B),
        .req_ack        (req_ack),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_err       (resp_err),
        .mult_start     (mult_start),
        .mult_ABus      (mult_ABus),
        .mult_BBus      (mult_BBus),
        .mult_ready     (mult_ready),
        .mult_resultBus (mult_resultBus),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return N;
    endfunction

    task automatic run_jobs(input int n_jobs, input bit keep, input int bp_id, input int bp_len);
        int done, cyc, held, g, ge;
        bit pend;
        logic [2*W-1:0] expv;
        done = 0; cyc = 0; held = 0; g = 0; ge = 0; pend = 1'b0; expv = '0;
        if (bp_id >= 0) resp_ready[bp_id] = 1'b0;
        while (done < n_jobs && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (|req_ack) begin
                ge = pick(rr_ptr, req);
                chk("ack_onehot", 32'($countones(req_ack)), 32'd1);
                chk("ack_while_pending", 32'(pend), 32'd0);
                chk("ack_grant", 32'(req_ack), 32'(1) << ge);
                g = ge % N;
                chk("grant_id", 32'(grant_id), 32'(ge));
                chk("start_at_ack", 32'(mult_start), 32'd1);
                chk("opA_latched", 32'(mult_ABus), 32'(req_A[g*W +: W]));
                chk("opB_latched", 32'(mult_BBus), 32'(req_B[g*W +: W]));
                expv = (2*W)'(req_A[g*W +: W]) * (2*W)'(req_B[g*W +: W]);
                rr_ptr = g; pend = 1'b1; held = 0;
                gq.push_back(g);
                if (!keep) req[g] = 1'b0;
                req_A[g*W +: W] = W'($urandom);
                req_B[g*W +: W] = W'($urandom);
            end
            if (|resp_valid) begin
                held++;
                chk("resp_valid", 32'(resp_valid), 32'(1) << g);
                chk("resp_result", 32'(resp_result), 32'(expv));
                chk("resp_err", 32'(resp_err), 32'd0);
                if (g == bp_id && held > bp_len) resp_ready[g] = 1'b1;
                if (resp_ready[g]) begin
                    done++; pend = 1'b0; held = 0;
                    rq.push_back(int'(resp_result));
                    if (done == n_jobs) req = '0;
                end
            end
        end
        chk("jobs_done", 32'(done), 32'(n_jobs));
    endtask

    initial begin
        int cyc;
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(mult_start), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: single job, 3*5, slow multiplier
        fixed_lat = 9;
        req_A[0 +: W] = 4'd3; req_B[0 +: W] = 4'd5; req[0] = 1'b1;
        rq.delete(); gq.delete();
        run_jobs(1, 1'b0, -1, 0);
        fixed_lat = 0;
        chk("t2_result", 32'(rq.size() > 0 ? rq[0] : -1), 32'h0F);

        // T1: asynchronous reset in the middle of WAIT_DONE
        fixed_lat = 12;
        req_A[W +: W] = W'($urandom); req_B[W +: W] = W'($urandom); req[1] = 1'b1;
        cyc = 0;
        while (!req_ack[1] && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t1_ack", 32'(req_ack[1]), 32'd1);
        req[1] = 1'b0;
        cyc = 0;
        while (mult_ready && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        chk("t1_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_start", 32'(mult_start), 32'd0);
        chk("t1_ack0", 32'(req_ack), 32'd0);
        chk("t1_valid", 32'(resp_valid), 32'd0);
        chk("t1_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_ptr = N - 1;
        repeat (2) @(negedge clk);
        chk("t1_idle", 32'(busy), 32'd0);
        fixed_lat = 0;
        cyc = 0;
        while (!mult_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t1_mult_idle", 32'(mult_ready), 32'd1);

        // T3: all four requesting continuously
        for (int i = 0; i < N; i++) begin
            req_A[i*W +: W] = W'(i + 1);
            req_B[i*W +: W] = W'(2);
        end
        rq.delete(); gq.delete();
        req = '1;
        run_jobs(5, 1'b1, -1, 0);
        for (int i = 0; i < 5; i++)
            chk("t3_order", 32'(gq.size() > i ? gq[i] : -1), 32'(i % N));
        for (int i = 0; i < 4; i++)
            chk("t3_result", 32'(rq.size() > i ? rq[i] : -1), 32'(2 * (i + 1)));

        // T4: backpressure on requester 1 for 7 cycles, random operands
        for (int i = 0; i < N; i++) begin
            req_A[i*W +: W] = W'($urandom);
            req_B[i*W +: W] = W'($urandom);
        end
        req = '1;
        run_jobs(4, 1'b1, 1, 7);
        resp_ready = '1;

        // T5: hung multiplier
        @(negedge clk);
        hang = 1'b1;
        req_A[2*W +: W] = W'($urandom); req_B[2*W +: W] = W'($urandom); req[2] = 1'b1;
        cyc = 0;
        while (!req_ack[2] && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t5_ack", 32'(req_ack[2]), 32'd1);
        req[2] = 1'b0;
        rr_ptr = 2;
        cyc = 0;
        while (resp_valid == '0 && cyc < T + 20) begin @(negedge clk); cyc++; end
        chk("t5_latency_window", 32'(cyc >= T && cyc <= T + 2), 32'd1);
        chk("t5_valid", 32'(resp_valid), 32'h4);
        chk("t5_err", 32'(resp_err), 32'd1);
        chk("t5_result", 32'(resp_result), 32'd0);
        chk("t5_start", 32'(mult_start), 32'd0);
        @(negedge clk);
        chk("t5_err_clear", 32'(resp_err), 32'd0);
        chk("t5_valid_clear", 32'(resp_valid), 32'd0);
        hang = 1'b0;
        cyc = 0;
        while (!mult_ready && cyc < 50) begin @(negedge clk); cyc++; end

        // T6: request waits while the multiplier is busy; max operands
        force_busy = 1'b1;
        req_A[3*W +: W] = 4'hF; req_B[3*W +: W] = 4'hF; req[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_ack", 32'(req_ack), 32'd0);
            chk("t6_not_busy", 32'(busy), 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("t6_ack", 32'(req_ack), 32'(1) << pick(rr_ptr, req));
        chk("t6_grant_id", 32'(grant_id), 32'd3);
        req[3] = 1'b0;
        cyc = 0;
        while (resp_valid == '0 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t6_valid", 32'(resp_valid), 32'h8);
        chk("t6_result", 32'(resp_result), 32'hE1);
        chk("t6_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        chk("t6_valid_clear", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
